// File: rtl/memwr_trace_pkg.sv
// Shared types for the memory-write trace UART.
// Latency: n/a (types, constants and a pure byte-select helper).
// Backpressure: n/a.
//
// Contents: TX FSM state enum, frame length, 24-bit write-event record and
// the helper that picks the n-th byte of a trace frame.
package memwr_trace_pkg;

    localparam int FRAME_BYTES = 4;
    localparam int EVT_W       = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } memwr_evt_t;

    // Frame byte order on the wire: sync, address, data high, data low.
    function automatic logic [7:0] frame_byte(input memwr_evt_t evt,
                                              input logic [1:0] idx,
                                              input logic [7:0] sync);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = evt.addr;
            2'd2:    b = evt.data[15:8];
            default: b = evt.data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// Latency: a push is visible on pop_dat/empty the cycle after it is accepted.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
//
// Ports: CLK, RST_N (sync active-low), push/push_dat, pop/pop_dat (show-ahead
// head of queue), full, empty, level (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/memwr_trace_uart.sv
// Streams every CPU data-memory write out of a UART as a 4-byte trace frame.
// Latency: write pulse at edge k into an idle, empty block gives the start bit at edge k+2.
// Backpressure: none upstream; events arriving with the FIFO full are dropped and OVF sticks.
//
// Ports: CLK, RST_N (sync active-low); cpuout_memupdate/memaddr/memdata write
// event; TX 8N1 serial out (idle high); BUSY frame in flight or events queued;
// OVF sticky drop flag; LEVEL FIFO occupancy.
module memwr_trace_uart
    import memwr_trace_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cpuout_memupdate,
    input  logic [7:0]  cpuout_memaddr,
    input  logic [15:0] cpuout_memdata,
    output logic        TX,
    output logic        BUSY,
    output logic        OVF,
    output logic [6:0]  LEVEL
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int               LVL_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(FRAME_BYTES - 1);

    memwr_evt_t       push_evt;
    memwr_evt_t       head_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             pop;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    memwr_evt_t       frame_q, frame_d;
    logic             tx_d;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign push_evt = '{addr: cpuout_memaddr, data: cpuout_memdata};

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (cpuout_memupdate),
        .push_dat (push_evt),
        .pop      (pop),
        .pop_dat  (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign LEVEL    = 7'(fifo_level);
    assign bit_end  = (cnt_q == BIT_LAST);
    assign cur_byte = frame_byte(frame_q, byte_q, SYNC_BYTE);

    // Next-state and line-level logic. tx_d is the level the line should carry
    // for the current state; it is registered into TX, so the whole waveform
    // trails the FSM by one cycle and never glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        // Bit timer reloads to zero on every bit boundary so periods never drift.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // Latch the event: later FIFO traffic cannot disturb this frame.
                    pop     = 1'b1;
                    frame_d = head_evt;
                    byte_d  = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_q];
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        // Always pass through IDLE between frames, even with work queued.
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            TX      <= 1'b1;
            BUSY    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            TX      <= tx_d;
            BUSY    <= (state_q != IDLE) || (fifo_level != '0);
            if (cpuout_memupdate && fifo_full && !pop) begin
                OVF <= 1'b1;
            end
        end
    end

endmodule
